load_m_strided: RTL and testbench

LOAD_M_STRIDED -- requirements
Module: load_m_strided

---
 rtl/tinyml_load_pkg.sv | 25 ++
 rtl/load_m_strided_mask.sv | 22 ++
 rtl/load_m_strided.sv | 220 ++++++++++++++++++++++
 tb/tb_load_m_strided.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyml_load_pkg.sv
// Shared definitions for the tile loaders: controller states and the
// tile/beat geometry derived from the bus and element widths.
package tinyml_load_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_EMIT  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } load_state_e;

   // Elements carried by one output tile.
   function automatic int tile_elems(input int tile_width, input int data_width);
      return tile_width / data_width;
   endfunction

   // Memory beats needed to fill one tile.
   function automatic int beats_per_tile(input int tile_width, input int data_width,
                                         input int beat_elems);
      return (tile_width / data_width) / beat_elems;
   endfunction

endpackage

// File: rtl/load_m_strided_mask.sv
// Zero-fills the elements of one fetched beat that fall at or beyond the
// matrix column count, so partial tiles at the right edge read as zero.
module load_beat_mask #(
   parameter int DATA_WIDTH = 8,
   parameter int BEAT_ELEMS = 4,
   parameter int DIM_WIDTH  = 10,
   parameter int COL_W      = 16
) (
   input  logic [BEAT_ELEMS*DATA_WIDTH-1:0] rdata_i,
   input  logic [COL_W-1:0]                 col_base_i,
   input  logic [DIM_WIDTH-1:0]             cols_i,
   output logic [BEAT_ELEMS*DATA_WIDTH-1:0] data_o
);

   for (genvar i = 0; i < BEAT_ELEMS; i++) begin : g_elem
      logic [COL_W:0] col;
      assign col = {1'b0, col_base_i} + (COL_W+1)'(i);
      assign data_o[i*DATA_WIDTH +: DATA_WIDTH] =
         (col < (COL_W+1)'(cols_i)) ? rdata_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
   end

endmodule

// File: rtl/load_m_strided.sv
// Strided matrix loader: walks a rows x cols element matrix in memory one
// beat at a time, assembles TILE_WIDTH-bit tiles in row-major order and
// hands them out over a valid/ready port. Columns past the matrix edge are
// zero-filled, and beats lying entirely past the edge are never fetched.
module load_m_strided
   import tinyml_load_pkg::*;
#(
   parameter int TILE_WIDTH = 256,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 24,
   parameter int BEAT_ELEMS = 4,
   parameter int DIM_WIDTH  = 10
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   output logic                             start_ready,
   input  logic [ADDR_WIDTH-1:0]            dram_addr,
   input  logic [DIM_WIDTH-1:0]             rows,
   input  logic [DIM_WIDTH-1:0]             cols,
   input  logic [ADDR_WIDTH-1:0]            row_stride,
   input  logic                             abort,
   output logic [TILE_WIDTH-1:0]            tile_data,
   output logic                             tile_valid,
   input  logic                             tile_ready,
   output logic                             tile_last_row,
   output logic                             tile_last,
   output logic                             done,
   output logic                             mem_req,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   input  logic [BEAT_ELEMS*DATA_WIDTH-1:0] mem_rdata,
   input  logic                             mem_valid
);

   localparam int TILE_ELEMS = tile_elems(TILE_WIDTH, DATA_WIDTH);
   localparam int BPT        = beats_per_tile(TILE_WIDTH, DATA_WIDTH, BEAT_ELEMS);
   localparam int BEAT_W     = BEAT_ELEMS * DATA_WIDTH;
   localparam int BW         = (BPT > 1) ? $clog2(BPT) : 1;
   // Column index width: covers every beat base of the widest legal row.
   localparam int CW         = DIM_WIDTH + $clog2(TILE_ELEMS) + 1;

   load_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0]  row_base_q, row_base_d;
   logic [ADDR_WIDTH-1:0]  stride_q, stride_d;
   logic [DIM_WIDTH-1:0]   rows_q, rows_d;
   logic [DIM_WIDTH-1:0]   cols_q, cols_d;
   logic [DIM_WIDTH-1:0]   tpr_q, tpr_d;
   logic [DIM_WIDTH-1:0]   row_q, row_d;
   logic [DIM_WIDTH-1:0]   tile_q, tile_d;
   logic [BW-1:0]          beat_q, beat_d;
   logic [BEAT_W-1:0]      beats_q [BPT];

   logic                   buf_we;
   logic [BEAT_W-1:0]      buf_wdata;
   logic [BEAT_W-1:0]      masked;
   logic [CW-1:0]          col_base;
   logic                   skip;
   logic                   last_beat;
   logic                   last_tile_row;
   logic                   last_row;
   logic [DIM_WIDTH:0]     tpr_new;
   logic [ADDR_WIDTH-1:0]  stride_new;

   // Job geometry derived from the request ports at acceptance time.
   assign tpr_new    = ({1'b0, cols} + (DIM_WIDTH+1)'(TILE_ELEMS - 1))
                       / (DIM_WIDTH+1)'(TILE_ELEMS);
   assign stride_new = (row_stride == '0)
                       ? ADDR_WIDTH'(tpr_new) * ADDR_WIDTH'(TILE_ELEMS)
                       : row_stride;

   assign col_base      = CW'(tile_q) * CW'(TILE_ELEMS) + CW'(beat_q) * CW'(BEAT_ELEMS);
   assign skip          = col_base >= CW'(cols_q);
   assign last_beat     = beat_q == BW'(BPT - 1);
   assign last_tile_row = tile_q == tpr_q - DIM_WIDTH'(1);
   assign last_row      = row_q == rows_q - DIM_WIDTH'(1);

   load_beat_mask #(
      .DATA_WIDTH (DATA_WIDTH),
      .BEAT_ELEMS (BEAT_ELEMS),
      .DIM_WIDTH  (DIM_WIDTH),
      .COL_W      (CW)
   ) u_mask (
      .rdata_i    (mem_rdata),
      .col_base_i (col_base),
      .cols_i     (cols_q),
      .data_o     (masked)
   );

   assign start_ready   = state_q == ST_IDLE;
   assign tile_valid    = state_q == ST_EMIT;
   assign tile_last_row = tile_valid && last_tile_row;
   assign tile_last     = tile_last_row && last_row;
   assign done          = state_q == ST_DONE;

   for (genvar b = 0; b < BPT; b++) begin : g_tile
      assign tile_data[b*BEAT_W +: BEAT_W] = beats_q[b];
   end

   // Next-state, counter advance, beat request and tile buffer write control.
   always_comb begin
      state_d    = state_q;
      row_base_d = row_base_q;
      stride_d   = stride_q;
      rows_d     = rows_q;
      cols_d     = cols_q;
      tpr_d      = tpr_q;
      row_d      = row_q;
      tile_d     = tile_q;
      beat_d     = beat_q;
      buf_we     = 1'b0;
      buf_wdata  = '0;
      mem_req    = 1'b0;
      mem_addr   = '0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               rows_d     = rows;
               cols_d     = cols;
               tpr_d      = tpr_new[DIM_WIDTH-1:0];
               stride_d   = stride_new;
               row_base_d = dram_addr;
               row_d      = '0;
               tile_d     = '0;
               beat_d     = '0;
               state_d    = (rows == '0 || cols == '0) ? ST_DONE : ST_REQ;
            end
         end
         ST_REQ: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (skip) begin
               // Beat lies wholly past the last column: fill zeros, no fetch.
               buf_we = 1'b1;
               if (last_beat) state_d = ST_EMIT;
               else           beat_d  = beat_q + BW'(1);
            end else begin
               mem_req  = 1'b1;
               mem_addr = row_base_q + ADDR_WIDTH'(col_base);
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_valid) begin
               buf_we    = 1'b1;
               buf_wdata = masked;
               if (abort) begin
                  state_d = ST_IDLE;
               end else if (last_beat) begin
                  state_d = ST_EMIT;
               end else begin
                  beat_d  = beat_q + BW'(1);
                  state_d = ST_REQ;
               end
            end else if (abort) begin
               state_d = ST_DRAIN;
            end
         end
         ST_EMIT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (tile_ready) begin
               beat_d = '0;
               if (last_tile_row) begin
                  tile_d = '0;
                  if (last_row) begin
                     state_d = ST_DONE;
                  end else begin
                     row_d      = row_q + DIM_WIDTH'(1);
                     row_base_d = row_base_q + stride_q;
                     state_d    = ST_REQ;
                  end
               end else begin
                  tile_d  = tile_q + DIM_WIDTH'(1);
                  state_d = ST_REQ;
               end
            end
         end
         ST_DRAIN: begin
            if (mem_valid) state_d = ST_IDLE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Controller state, job registers and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         row_base_q <= '0;
         stride_q   <= '0;
         rows_q     <= '0;
         cols_q     <= '0;
         tpr_q      <= '0;
         row_q      <= '0;
         tile_q     <= '0;
         beat_q     <= '0;
      end else begin
         state_q    <= state_d;
         row_base_q <= row_base_d;
         stride_q   <= stride_d;
         rows_q     <= rows_d;
         cols_q     <= cols_d;
         tpr_q      <= tpr_d;
         row_q      <= row_d;
         tile_q     <= tile_d;
         beat_q     <= beat_d;
      end
   end

   // Tile assembly buffer, one slot per beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < BPT; b++) beats_q[b] <= '0;
      end else if (buf_we) begin
         beats_q[beat_q] <= buf_wdata;
      end
   end

endmodule

// File: tb/tb_load_m_strided.sv
// Randomized and directed bench for load_m_strided against a row/column
// level reference model of the expected request and tile streams.
module tb_load_m_strided;

   localparam int TW = 256;
   localparam int DW = 8;
   localparam int AW = 24;
   localparam int BE = 4;
   localparam int DMW = 10;
   localparam int TE = TW / DW;

   typedef struct {
      logic [TW-1:0] d;
      bit            lr;
      bit            last;
   } tile_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic           start_ready;
   logic [AW-1:0]  dram_addr;
   logic [DMW-1:0] rows;
   logic [DMW-1:0] cols;
   logic [AW-1:0]  row_stride;
   logic           abort;
   logic [TW-1:0]  tile_data;
   logic           tile_valid;
   logic           tile_ready;
   logic           tile_last_row;
   logic           tile_last;
   logic           done;
   logic           mem_req;
   logic [AW-1:0]  mem_addr;
   logic [BE*DW-1:0] mem_rdata;
   logic           mem_valid;

   int n_checks = 0;
   int n_errors = 0;

   logic [AW-1:0] exp_addr[$];
   tile_t         exp_tile[$];
   int            done_cnt = 0;
   int            n_tiles  = 0;
   int            lat_cfg  = 0;
   int            rdy_pct  = 100;
   int            stall_left = 0;
   bit            mem_ff = 0;

   load_m_strided #(
      .TILE_WIDTH (TW), .DATA_WIDTH (DW), .ADDR_WIDTH (AW),
      .BEAT_ELEMS (BE), .DIM_WIDTH (DMW)
   ) dut (
      .clk (clk), .rst_n (rst_n), .start (start), .start_ready (start_ready),
      .dram_addr (dram_addr), .rows (rows), .cols (cols), .row_stride (row_stride),
      .abort (abort), .tile_data (tile_data), .tile_valid (tile_valid),
      .tile_ready (tile_ready), .tile_last_row (tile_last_row), .tile_last (tile_last),
      .done (done), .mem_req (mem_req), .mem_addr (mem_addr),
      .mem_rdata (mem_rdata), .mem_valid (mem_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
      logic [7:0] lo;
      if (mem_ff) return 8'hFF;
      lo = a[7:0];
      return (lo * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'hA5;
   endfunction

   // Reference: full request list and tile contents for a job.
   task automatic build_model(input logic [AW-1:0] a, input int r, input int c,
                              input logic [AW-1:0] s);
      int tpr;
      logic [AW-1:0] stride, rb;
      tile_t t;
      exp_addr.delete();
      exp_tile.delete();
      if (r == 0 || c == 0) return;
      tpr    = (c + TE - 1) / TE;
      stride = (s == 0) ? AW'(tpr * TE) : s;
      for (int ri = 0; ri < r; ri++) begin
         rb = a + AW'(ri) * stride;
         for (int ti = 0; ti < tpr; ti++) begin
            for (int cb = ti * TE; cb < (ti + 1) * TE; cb += BE)
               if (cb < c) exp_addr.push_back(rb + AW'(cb));
            t.d = '0;
            for (int e = 0; e < TE; e++)
               if (ti * TE + e < c) t.d[e*DW +: DW] = mem_byte(rb + AW'(ti * TE + e));
            t.lr   = (ti == tpr - 1);
            t.last = (ti == tpr - 1) && (ri == r - 1);
            exp_tile.push_back(t);
         end
      end
   endtask

   // Memory responder, tile sink and protocol monitor, all on the falling edge.
   initial begin
      int resp_cnt = 0;
      logic [AW-1:0] resp_addr = '0;
      bit stall_prev = 0, resume_due = 0, busy;
      logic [TW-1:0] held_d = '0;
      logic held_lr = 0, held_last = 0;
      tile_t t;
      mem_valid = 0; mem_rdata = '0; tile_ready = 0;
      forever begin
         @(negedge clk);
         busy = resp_cnt != 0;
         if (mem_valid) mem_valid = 0;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               mem_valid = 1;
               for (int i = 0; i < BE; i++) mem_rdata[i*DW +: DW] = mem_byte(resp_addr + AW'(i));
            end
         end
         if (resume_due) chk("resume_req", TW'(mem_req), TW'(1));
         resume_due = 0;
         if (mem_req) begin
            chk("req_overlap", TW'(busy), TW'(0));
            chk("req_during_tile", TW'(tile_valid), TW'(0));
            if (exp_addr.size() == 0) chk("req_unexpected", TW'(mem_addr), '1);
            else chk("req_addr", TW'(mem_addr), TW'(exp_addr.pop_front()));
            resp_addr = mem_addr;
            resp_cnt  = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 3));
         end
         if (stall_prev && tile_valid) begin
            chk("stable_data", tile_data, held_d);
            chk("stable_flags", TW'({tile_last_row, tile_last}), TW'({held_lr, held_last}));
         end
         if (stall_left > 0 && tile_valid) begin
            tile_ready = 0;
            stall_left--;
         end else begin
            tile_ready = ($urandom_range(0, 99) < rdy_pct);
         end
         if (tile_valid && tile_ready) begin
            n_tiles++;
            if (exp_tile.size() == 0) begin
               chk("tile_unexpected", TW'(1), TW'(0));
            end else begin
               t = exp_tile.pop_front();
               chk("tile_data", tile_data, t.d);
               chk("tile_flags", TW'({tile_last_row, tile_last}), TW'({t.lr, t.last}));
            end
            resume_due = !tile_last;
         end
         stall_prev = tile_valid && !tile_ready;
         held_d = tile_data; held_lr = tile_last_row; held_last = tile_last;
         if (done) done_cnt++;
      end
   end

   task automatic run_job(input logic [AW-1:0] a, input int r, input int c,
                          input logic [AW-1:0] s);
      int d0, cyc;
      build_model(a, r, c, s);
      d0 = done_cnt;
      @(posedge clk); #1;
      dram_addr = a; rows = DMW'(r); cols = DMW'(c); row_stride = s;
      chk("start_ready", TW'(start_ready), TW'(1));
      start = 1;
      @(posedge clk); #1;
      start = 0;
      if (r == 0 || c == 0) chk("zero_done", TW'({done, mem_req}), TW'(2'b10));
      else chk("first_req", TW'(mem_req), TW'(1));
      cyc = 0;
      while (done_cnt == d0 && cyc < 4000) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (done_cnt == d0) begin
         chk("done_timeout", TW'(0), TW'(1));
         rst_n = 0; #2; rst_n = 1;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reqs_left", TW'(exp_addr.size()), TW'(0));
      chk("tiles_left", TW'(exp_tile.size()), TW'(0));
      chk("done_once", TW'(done_cnt - d0), TW'(1));
   endtask

   initial begin
      int d0, t0;
      logic [AW-1:0] ra, rs;
      rst_n = 0; start = 0; abort = 0;
      dram_addr = '0; rows = '0; cols = '0; row_stride = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", TW'(start_ready), TW'(1));
      chk("rst_req", TW'({mem_req, mem_addr}), TW'(0));
      chk("rst_tile", TW'({tile_valid, tile_last_row, tile_last, done}), TW'(0));
      chk("rst_data", tile_data, '0);
      rst_n = 1;

      run_job(24'h100, 2, 32, 0);
      run_job(24'h0, 1, 40, 0);
      mem_ff = 1;
      run_job(24'h2000, 1, 34, 0);
      mem_ff = 0;
      run_job(24'h0, 3, 8, 24'd100);
      stall_left = 5;
      run_job(24'h40, 1, 64, 0);
      run_job(24'h10, 0, 20, 0);

      // Abort while waiting for a response.
      lat_cfg = 3;
      build_model(24'h0, 1, 32, 0);
      d0 = done_cnt; t0 = n_tiles;
      @(posedge clk); #1;
      dram_addr = '0; rows = 1; cols = 32; row_stride = '0; start = 1;
      @(posedge clk); #1;
      start = 0;
      chk("abort_first_req", TW'(mem_req), TW'(1));
      @(posedge clk); #1;
      abort = 1;
      exp_addr.delete(); exp_tile.delete();
      @(posedge clk); #1;
      abort = 0;
      chk("drain_busy", TW'(start_ready), TW'(0));
      @(posedge clk); #1;
      chk("drain_hold", TW'(start_ready), TW'(0));
      @(posedge clk); #1;
      chk("drain_exit", TW'(start_ready), TW'(1));
      repeat (4) @(posedge clk);
      #1;
      chk("abort_no_done", TW'(done_cnt - d0), TW'(0));
      chk("abort_no_tile", TW'(n_tiles - t0), TW'(0));

      // Reset mid-job, leaving a response in flight.
      build_model(24'h300, 2, 64, 0);
      d0 = done_cnt; t0 = n_tiles;
      @(posedge clk); #1;
      dram_addr = 24'h300; rows = 2; cols = 64; row_stride = '0; start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      chk("midrst_state", TW'({start_ready, mem_req, tile_valid, done}), TW'(4'b1000));
      chk("midrst_data", tile_data, '0);
      exp_addr.delete(); exp_tile.delete();
      @(posedge clk); #1;
      rst_n = 1;
      repeat (6) @(posedge clk);
      #1;
      chk("midrst_idle", TW'(start_ready), TW'(1));
      chk("midrst_quiet", TW'({done_cnt - d0, n_tiles - t0}), TW'(0));
      lat_cfg = 0;

      // Randomized jobs with back-pressure.
      rdy_pct = 70;
      for (int j = 0; j < 10; j++) begin
         ra = ($urandom_range(0, 3) == 0) ? 24'hFFFFF0 : AW'($urandom);
         rs = ($urandom_range(0, 1) == 0) ? '0 : AW'($urandom_range(1, 400));
         run_job(ra, $urandom_range(0, 3), $urandom_range(0, 100), rs);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
